addsub_accum_pipe: RTL and testbench
====================================

Name: addsub_accum_pipe

Overview:
Next-generation parametrised adder/subtractor for the DSP48A1 datapath.
- Replaces the fixed 18-bit combinational unit with a registered, WIDTH-generic unit.
- Adds correct MSB-based overflow detection for add and subtract, signed and unsigned modes, optional saturation, accumulate feedback, a sticky overflow flag and valid tracking.
- Sits in the post-adder position feeding the P output path.

Parameters:
- WIDTH, 18, operand and result width (>=4).
- IN_REG, 1, 1 = register A/B/control at input (stage S0); 0 = pass through.
- OUT_REG, 1, 1 = extra output register stage (S2); 0 = outputs driven from compute register.
- SIGNED, 1, 1 = two's-complement overflow rules; 0 = unsigned rules.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- CE  in  1  clock enable for all stages; 0 freezes every register, including the sticky flag.
- in_valid  in  1  qualifies A/B/control this cycle.
- A  in  WIDTH  operand 0.
- B  in  WIDTH  operand 1.
- SUB  in  1  0 = add, 1 = subtract.
- CIN  in  1  carry-in.
- ACC  in  1  1 = use accumulator (compute register) in place of A.
- SAT_EN  in  1  1 = saturate on overflow; 0 = wrap.
- CLR_OVF  in  1  clears OVF_STICKY.
- out_valid  out  1  P/COUT/OVF are valid.
- P  out  WIDTH  result.
- COUT  out  1  carry (add) / borrow (sub) out of bit WIDTH-1.
- OVF  out  1  overflow occurred on this result.
- OVF_STICKY  out  1  set on any valid overflow until cleared.

Behaviour:
- Reset (RST_n=0, async): every register cleared: P=0, COUT=0, OVF=0, OVF_STICKY=0, out_valid=0, accumulator=0. Release takes effect on the next CLK edge.
- Pipeline: S0 (if IN_REG), S1 compute register (always present, also the accumulator), S2 (if OUT_REG). Latency from in_valid to out_valid = 1+IN_REG+OUT_REG cycles.
- All stages advance only when CE=1. With CE=0, all state holds, including outputs and the sticky flag.
- Bubble handling: valid shifts with data. When a stage's valid is 0, S1 does not update the accumulator/result but its valid bit clears.
- Operand select at S1: X = ACC ? S1 result register : A (after S0). Back-to-back ACC beats therefore chain each cycle.
- Arithmetic is performed at WIDTH+1 bits:
  - add: {c,r} = X + B + CIN
  - sub: {c,r} = X - B - CIN, with c = borrow
- Overflow, SIGNED=1:
  - add: X[MSB]==B[MSB] and r[MSB]!=X[MSB].
  - sub: X[MSB]!=B[MSB] and r[MSB]!=X[MSB].
  - CIN is included in r.
- Overflow, SIGNED=0: ovf = c, for both add and sub.
- Saturation (SAT_EN=1 and ovf=1):
  - Signed: P = X[MSB]==0 ? max positive (0 followed by all 1s) : min negative (1 followed by all 0s).
  - Unsigned: add → all 1s; sub → 0.
  - COUT is forced to 0 when saturating. The accumulator takes the saturated value.
- Wrap (SAT_EN=0): P=r and COUT=c. OVF still reports the overflow.
- OVF_STICKY:
  - Set when a valid result with ovf=1 is registered in S1.
  - CLR_OVF with CE=1 clears it.
  - If a clear and a new overflow occur in the same cycle, set wins.
  - The flag reflects S1 timing (not delayed by S2).
- Reset asserted mid-accumulation discards all in-flight beats. The first valid beat after reset with ACC=1 accumulates onto 0.

Decomposition:
- Package addsub_pkg:
  - max/min saturation constant functions of WIDTH.
  - ovf_detect(x,b,r,c,sub,signed) function.
  - saturate() function.
- One combinational sub-module, addsub_core: operand arithmetic, overflow, saturation. It is instantiated in S1 and the wrapper holds all registers.

Test Plan:
- WIDTH=18, SIGNED=1, IN_REG=OUT_REG=1, SAT_EN=0: A=1000, B=234, CIN=1, add → after 3 cycles P=1235, COUT=0, OVF=0, out_valid=1 for exactly one cycle.
- Signed positive overflow: A=0x1FFFF, B=1, add, SAT_EN=1 → P=0x1FFFF, OVF=1, OVF_STICKY=1. Repeat with SAT_EN=0 → P=0x20000, OVF=1.
- Signed subtract underflow: A=0x20000, B=1, SUB=1, SAT_EN=1 → P=0x20000, OVF=1. Then CLR_OVF pulse with no new overflow → OVF_STICKY=0. Clear coincident with a new overflow → stays 1.
- Accumulate: five consecutive beats B=10, ACC=1 from reset → P sequence 10, 20, 30, 40, 50. Insert an in_valid=0 bubble and a CE=0 cycle mid-stream → accumulator unchanged, no duplicate out_valid.
- SIGNED=0: A=5, B=7, SUB=1 → wrap gives P=0x3FFFE, COUT=1, OVF=1; SAT_EN=1 gives P=0.
- RST_n asserted asynchronously between clock edges with two beats in flight → outputs go to 0 immediately. The next ACC beat B=3 yields P=3.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pkg
// Purpose : Saturation limits, overflow rule and saturation select shared by
//           the adder/subtractor datapath.
// Rev     : 1.0
// ============================================================================
package addsub_pkg;

  // Limits are built at 64 bits and narrowed by the caller (WIDTH <= 63).
  function automatic logic [63:0] sat_max(input int w, input logic sgn);
    return sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input int w, input logic sgn);
    return sgn ? (64'd1 << (w - 1)) : 64'd0;
  endfunction

  function automatic logic ovf_detect(input logic x_msb, input logic b_msb,
                                      input logic r_msb, input logic c,
                                      input logic sub, input logic sgn);
    if (!sgn)
      return c;
    if (sub)
      return (x_msb != b_msb) && (r_msb != x_msb);
    return (x_msb == b_msb) && (r_msb != x_msb);
  endfunction

  function automatic logic [63:0] saturate(input int w, input logic x_msb,
                                           input logic sub, input logic sgn);
    if (sgn)
      return x_msb ? sat_min(w, 1'b1) : sat_max(w, 1'b1);
    return sub ? sat_min(w, 1'b0) : sat_max(w, 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_core.sv
`default_nettype none
// ============================================================================
// Module  : addsub_core
// Purpose : Combinational add/subtract with carry/borrow, overflow detection
//           and optional saturation.
// Rev     : 1.0
// ============================================================================
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  input  logic             i_sat_en,
  output logic [WIDTH-1:0] o_p,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sat;
  logic             w_ovf;

  // Bit WIDTH of the extended result is the carry for add and the borrow for sub.
  always_comb begin
    if (i_sub)
      w_sum = {1'b0, i_x} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_cin};
    else
      w_sum = {1'b0, i_x} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  end

  assign w_ovf = ovf_detect(i_x[WIDTH-1], i_b[WIDTH-1], w_sum[WIDTH-1],
                            w_sum[WIDTH], i_sub, SIGNED);
  assign w_sat = WIDTH'(saturate(WIDTH, i_x[WIDTH-1], i_sub, SIGNED));

  always_comb begin
    o_p    = w_sum[WIDTH-1:0];
    o_cout = w_sum[WIDTH];
    if (i_sat_en && w_ovf) begin
      o_p    = w_sat;
      o_cout = 1'b0;
    end
  end

  assign o_ovf = w_ovf;

endmodule
`default_nettype wire

// File: rtl/addsub_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module  : addsub_accum_pipe
// Purpose : Registered add/subtract/accumulate unit with optional input and
//           output stages, saturation and a sticky overflow flag.
// Rev     : 1.0
// ============================================================================
module addsub_accum_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter bit IN_REG  = 1'b1,
  parameter bit OUT_REG = 1'b1,
  parameter bit SIGNED  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  input  logic             ACC,
  input  logic             SAT_EN,
  input  logic             CLR_OVF,
  output logic             out_valid,
  output logic [WIDTH-1:0] P,
  output logic             COUT,
  output logic             OVF,
  output logic             OVF_STICKY
);

  logic             w_s0_valid;
  logic [WIDTH-1:0] w_s0_a;
  logic [WIDTH-1:0] w_s0_b;
  logic             w_s0_sub;
  logic             w_s0_cin;
  logic             w_s0_acc;
  logic             w_s0_sat;

  generate
    if (IN_REG) begin : g_in_reg
      logic             r_valid;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic             r_sub;
      logic             r_cin;
      logic             r_acc;
      logic             r_sat;

      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          r_valid <= 1'b0;
          r_a     <= '0;
          r_b     <= '0;
          r_sub   <= 1'b0;
          r_cin   <= 1'b0;
          r_acc   <= 1'b0;
          r_sat   <= 1'b0;
        end else if (CE) begin
          r_valid <= in_valid;
          r_a     <= A;
          r_b     <= B;
          r_sub   <= SUB;
          r_cin   <= CIN;
          r_acc   <= ACC;
          r_sat   <= SAT_EN;
        end
      end

      assign w_s0_valid = r_valid;
      assign w_s0_a     = r_a;
      assign w_s0_b     = r_b;
      assign w_s0_sub   = r_sub;
      assign w_s0_cin   = r_cin;
      assign w_s0_acc   = r_acc;
      assign w_s0_sat   = r_sat;
    end else begin : g_in_pass
      assign w_s0_valid = in_valid;
      assign w_s0_a     = A;
      assign w_s0_b     = B;
      assign w_s0_sub   = SUB;
      assign w_s0_cin   = CIN;
      assign w_s0_acc   = ACC;
      assign w_s0_sat   = SAT_EN;
    end
  endgenerate

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_p;
  logic             r_s1_cout;
  logic             r_s1_ovf;
  logic             r_sticky;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_p;
  logic             w_cout;
  logic             w_ovf;

  // The S1 result register doubles as the accumulator.
  assign w_x = w_s0_acc ? r_s1_p : w_s0_a;

  addsub_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .i_x      (w_x),
    .i_b      (w_s0_b),
    .i_sub    (w_s0_sub),
    .i_cin    (w_s0_cin),
    .i_sat_en (w_s0_sat),
    .o_p      (w_p),
    .o_cout   (w_cout),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_cout  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_sticky   <= 1'b0;
    end else if (CE) begin
      r_s1_valid <= w_s0_valid;
      if (w_s0_valid) begin
        r_s1_p    <= w_p;
        r_s1_cout <= w_cout;
        r_s1_ovf  <= w_ovf;
      end
      // A new overflow outranks a coincident clear.
      if (w_s0_valid && w_ovf)
        r_sticky <= 1'b1;
      else if (CLR_OVF)
        r_sticky <= 1'b0;
    end
  end

  assign OVF_STICKY = r_sticky;

  generate
    if (OUT_REG) begin : g_out_reg
      logic             r_valid;
      logic [WIDTH-1:0] r_p;
      logic             r_cout;
      logic             r_ovf;

      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          r_valid <= 1'b0;
          r_p     <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (CE) begin
          r_valid <= r_s1_valid;
          r_p     <= r_s1_p;
          r_cout  <= r_s1_cout;
          r_ovf   <= r_s1_ovf;
        end
      end

      assign out_valid = r_valid;
      assign P         = r_p;
      assign COUT      = r_cout;
      assign OVF       = r_ovf;
    end else begin : g_out_pass
      assign out_valid = r_s1_valid;
      assign P         = r_s1_p;
      assign COUT      = r_s1_cout;
      assign OVF       = r_s1_ovf;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_addsub_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_accum_pipe
// Purpose : Self-checking bench: directed vectors, corner sequences and a
//           randomized stream against an arithmetic reference model.
// Rev     : 1.0
// ============================================================================
module tb_addsub_accum_pipe;

  localparam int     W    = 18;
  localparam longint MASK = (64'sd1 <<< W) - 1;
  localparam longint HALF = 64'sd1 <<< (W - 1);

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic         CE = 1'b0;
  logic         in_valid = 1'b0;
  logic         SUB = 1'b0;
  logic         CIN = 1'b0;
  logic         ACC = 1'b0;
  logic         SAT_EN = 1'b0;
  logic         CLR_OVF = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic         ov_s, co_s, of_s, st_s;
  logic         ov_u, co_u, of_u, st_u;
  logic [W-1:0] p_s, p_u;

  always #5 CLK = ~CLK;

  addsub_accum_pipe #(.WIDTH(W), .IN_REG(1'b1), .OUT_REG(1'b1), .SIGNED(1'b1)) dut_s (
    .CLK(CLK), .RST_n(RST_n), .CE(CE), .in_valid(in_valid), .A(A), .B(B),
    .SUB(SUB), .CIN(CIN), .ACC(ACC), .SAT_EN(SAT_EN), .CLR_OVF(CLR_OVF),
    .out_valid(ov_s), .P(p_s), .COUT(co_s), .OVF(of_s), .OVF_STICKY(st_s)
  );

  addsub_accum_pipe #(.WIDTH(W), .IN_REG(1'b1), .OUT_REG(1'b1), .SIGNED(1'b0)) dut_u (
    .CLK(CLK), .RST_n(RST_n), .CE(CE), .in_valid(in_valid), .A(A), .B(B),
    .SUB(SUB), .CIN(CIN), .ACC(ACC), .SAT_EN(SAT_EN), .CLR_OVF(CLR_OVF),
    .out_valid(ov_u), .P(p_u), .COUT(co_u), .OVF(of_u), .OVF_STICKY(st_u)
  );

  typedef struct {
    longint p;
    bit     c;
    bit     o;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sub;
    bit           cin;
    bit           sat;
    longint       p;
    bit           c;
    bit           o;
  } vec_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  res_t   exp_s[$], exp_u[$], got_s[$], got_u[$];
  longint acc_s = 0;
  longint acc_u = 0;
  vec_t   vt[8];

  // Reference: exact integer result, overflow = result outside the mode's range.
  function automatic res_t model(input longint x, input longint b, input bit sub,
                                 input bit cin, input bit sat, input bit sgn);
    res_t   r;
    longint xs, bs, ci, t, tu;
    xs = x;
    bs = b;
    ci = longint'(cin);
    if (sgn) begin
      if (x >= HALF) xs = x - 2 * HALF;
      if (b >= HALF) bs = b - 2 * HALF;
    end
    t    = sub ? (xs - bs - ci) : (xs + bs + ci);
    tu   = sub ? (x - b - ci) : (x + b + ci);
    r.p  = t & MASK;
    r.c  = sub ? (tu < 0) : (tu > MASK);
    r.o  = sgn ? ((t > HALF - 1) || (t < -HALF)) : r.c;
    if (sat && r.o) begin
      r.c = 1'b0;
      if (sgn) r.p = (t > 0) ? (HALF - 1) : HALF;
      else     r.p = sub ? 0 : MASK;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // One clock; the model consumes a beat whenever the DUT would accept one.
  task automatic tick(input bit ce);
    res_t rs, ru;
    CE = ce;
    if (ce && in_valid) begin
      rs = model(ACC ? acc_s : longint'(A), longint'(B), SUB, CIN, SAT_EN, 1'b1);
      ru = model(ACC ? acc_u : longint'(A), longint'(B), SUB, CIN, SAT_EN, 1'b0);
      acc_s = rs.p;
      acc_u = ru.p;
      exp_s.push_back(rs);
      exp_u.push_back(ru);
    end
    @(posedge CLK);
    #1;
    if (ce && ov_s) got_s.push_back('{longint'(p_s), co_s, of_s});
    if (ce && ov_u) got_u.push_back('{longint'(p_u), co_u, of_u});
  endtask

  task automatic clear_model();
    exp_s.delete(); exp_u.delete(); got_s.delete(); got_u.delete();
    acc_s = 0;
    acc_u = 0;
  endtask

  task automatic do_reset();
    RST_n = 1'b0; in_valid = 1'b0; CE = 1'b1; CLR_OVF = 1'b0; ACC = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    clear_model();
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                      input bit cin, input bit acc, input bit sat);
    A = a; B = b; SUB = sub; CIN = cin; ACC = acc; SAT_EN = sat; in_valid = 1'b1;
  endtask

  function automatic longint pack(input res_t r);
    return r.p * 4 + longint'(r.c) * 2 + longint'(r.o);
  endfunction

  initial begin
    vt[0] = '{18'd1000,    18'd234,   1'b0, 1'b1, 1'b0, 1235,     1'b0, 1'b0};
    vt[1] = '{18'h1FFFF,   18'd1,     1'b0, 1'b0, 1'b1, 'h1FFFF,  1'b0, 1'b1};
    vt[2] = '{18'h1FFFF,   18'd1,     1'b0, 1'b0, 1'b0, 'h20000,  1'b0, 1'b1};
    vt[3] = '{18'h20000,   18'd1,     1'b1, 1'b0, 1'b1, 'h20000,  1'b0, 1'b1};
    vt[4] = '{18'h20000,   18'd1,     1'b1, 1'b0, 1'b0, 'h1FFFF,  1'b0, 1'b1};
    vt[5] = '{18'd5,       18'd7,     1'b1, 1'b0, 1'b0, 'h3FFFE,  1'b1, 1'b0};
    vt[6] = '{18'h3FFFF,   18'd1,     1'b0, 1'b0, 1'b1, 0,        1'b1, 1'b0};
    vt[7] = '{18'd0,       18'd0,     1'b1, 1'b1, 1'b0, 'h3FFFF,  1'b1, 1'b0};

    do_reset();
    chk("reset P", longint'(p_s), 0);
    chk("reset out_valid", longint'(ov_s), 0);
    chk("reset sticky", longint'(st_s), 0);

    // Directed signed vectors: latency 3, out_valid exactly one cycle.
    for (int i = 0; i < 8; i++) begin
      beat(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, 1'b0, vt[i].sat);
      tick(1'b1);
      in_valid = 1'b0;
      tick(1'b1);
      chk($sformatf("vec%0d early valid", i), longint'(ov_s), 0);
      tick(1'b1);
      chk($sformatf("vec%0d valid", i), longint'(ov_s), 1);
      chk($sformatf("vec%0d P", i), longint'(p_s), vt[i].p);
      chk($sformatf("vec%0d COUT", i), longint'(co_s), longint'(vt[i].c));
      chk($sformatf("vec%0d OVF", i), longint'(of_s), longint'(vt[i].o));
      tick(1'b1);
      chk($sformatf("vec%0d valid drop", i), longint'(ov_s), 0);
    end

    // Sticky: set by the earlier overflows, CE=0 blocks clear, clear works, set beats clear.
    chk("sticky set", longint'(st_s), 1);
    CLR_OVF = 1'b1;
    tick(1'b0);
    chk("sticky held ce0", longint'(st_s), 1);
    tick(1'b1);
    CLR_OVF = 1'b0;
    chk("sticky cleared", longint'(st_s), 0);
    beat(18'h1FFFF, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    in_valid = 1'b0;
    CLR_OVF = 1'b1;
    tick(1'b1);
    CLR_OVF = 1'b0;
    chk("sticky set wins", longint'(st_s), 1);
    repeat (3) tick(1'b1);

    // Accumulate chain with a bubble and a CE=0 stall.
    do_reset();
    beat(18'd12345, 18'd10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    tick(1'b1);
    in_valid = 1'b0;
    tick(1'b1);
    in_valid = 1'b1;
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b1);
    in_valid = 1'b0;
    repeat (5) tick(1'b1);
    chk("acc count", longint'(got_s.size()), 5);
    for (int i = 0; i < 5 && i < got_s.size(); i++)
      chk($sformatf("acc beat%0d P", i), got_s[i].p, 10 * (i + 1));

    // Unsigned rules: borrow is overflow; saturated subtract clamps to zero.
    do_reset();
    beat(18'd5, 18'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    in_valid = 1'b0;
    repeat (2) tick(1'b1);
    chk("uns wrap P", longint'(p_u), 'h3FFFE);
    chk("uns wrap COUT", longint'(co_u), 1);
    chk("uns wrap OVF", longint'(of_u), 1);
    chk("uns sticky", longint'(st_u), 1);
    beat(18'd5, 18'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1);
    in_valid = 1'b0;
    repeat (2) tick(1'b1);
    chk("uns sat P", longint'(p_u), 0);
    chk("uns sat COUT", longint'(co_u), 0);
    chk("uns sat OVF", longint'(of_u), 1);

    // Asynchronous reset between edges with beats in flight.
    do_reset();
    beat(18'd0, 18'd100, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1);
    in_valid = 1'b0;
    chk("pre-reset P", longint'(p_s), 100);
    #3;
    RST_n = 1'b0;
    #1;
    chk("async rst P", longint'(p_s), 0);
    chk("async rst valid", longint'(ov_s), 0);
    chk("async rst uns P", longint'(p_u), 0);
    #2;
    RST_n = 1'b1;
    clear_model();
    beat(18'd0, 18'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    in_valid = 1'b0;
    tick(1'b1);
    chk("post-rst no stale beat", longint'(ov_s), 0);
    tick(1'b1);
    chk("post-rst P", longint'(p_s), 3);
    chk("post-rst valid", longint'(ov_s), 1);
    chk("post-rst uns P", longint'(p_u), 3);

    // Randomized stream against the reference model, both signedness modes.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: A = '0;
        1: A = W'(MASK);
        2: A = W'(HALF - 1);
        3: A = W'(HALF);
        default: A = W'($urandom);
      endcase
      B        = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      SUB      = 1'($urandom);
      CIN      = 1'($urandom);
      ACC      = 1'($urandom);
      SAT_EN   = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 9) != 0);
    end
    in_valid = 1'b0;
    repeat (6) tick(1'b1);
    chk("rand signed count", longint'(got_s.size()), longint'(exp_s.size()));
    chk("rand unsigned count", longint'(got_u.size()), longint'(exp_u.size()));
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
      chk($sformatf("rand s%0d {P,COUT,OVF}", i), pack(got_s[i]), pack(exp_s[i]));
    for (int i = 0; i < got_u.size() && i < exp_u.size(); i++)
      chk($sformatf("rand u%0d {P,COUT,OVF}", i), pack(got_u[i]), pack(exp_u[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
